// File: rtl/alu_pkg.sv
// alu_pkg: shared types for the pipelined ALU.
//   OP_W      - opcode width
//   alu_op_t  - opcode encoding seen on the pipelined_alu op port
//   is_sub_path() - opcodes that run the adder as a - b (with optional borrow)
package alu_pkg;

  localparam int OP_W = 4;

  typedef enum logic [OP_W-1:0] {
    OP_ADD     = 4'd0,
    OP_SUB     = 4'd1,
    OP_ADC     = 4'd2,
    OP_SBB     = 4'd3,
    OP_AND     = 4'd4,
    OP_OR      = 4'd5,
    OP_XOR     = 4'd6,
    OP_NAND    = 4'd7,
    OP_NOR     = 4'd8,
    OP_CMP_EQ  = 4'd9,
    OP_CMP_LT  = 4'd10,
    OP_CMP_LTU = 4'd11,
    OP_SLL     = 4'd12,
    OP_SRL     = 4'd13,
    OP_SRA     = 4'd14,
    OP_PASS_A  = 4'd15
  } alu_op_t;

  // Compares reuse the subtract datapath, so they invert b like SUB/SBB.
  function automatic logic is_sub_path(input alu_op_t op);
    return (op == OP_SUB) || (op == OP_SBB) || (op == OP_CMP_LT) || (op == OP_CMP_LTU);
  endfunction

endpackage

// File: rtl/cla_adder_n.sv
// cla_adder_n: combinational block carry-lookahead adder.
//   a, b          - WIDTH-bit addends
//   cin           - carry into bit 0
//   sum           - WIDTH-bit sum
//   cout          - carry out of the MSB
//   msb_carry_in  - carry into the MSB (cout ^ msb_carry_in is signed overflow)
// Bits are split into CLA_GROUP-bit groups. Every group carry-in is a flat
// sum of products of group generate/propagate terms, so no carry ripples
// from one group into the next; only the short in-group chain remains.
module cla_adder_n #(
  parameter int WIDTH     = 16,
  parameter int CLA_GROUP = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             msb_carry_in
);

  localparam int NG = WIDTH / CLA_GROUP;

  logic [WIDTH-1:0] gen;
  logic [WIDTH-1:0] prop;
  logic [NG-1:0]    grp_g;
  logic [NG-1:0]    grp_p;
  logic [NG:0]      grp_c;
  logic [WIDTH:0]   c;

  assign gen  = a & b;
  assign prop = a ^ b;

  // Group generate/propagate from the bit terms of each group.
  always_comb begin
    grp_g = '0;
    grp_p = '0;
    for (int k = 0; k < NG; k++) begin
      grp_p[k] = &prop[k*CLA_GROUP +: CLA_GROUP];
      for (int i = 0; i < CLA_GROUP; i++) begin
        grp_g[k] = gen[k*CLA_GROUP+i] | (prop[k*CLA_GROUP+i] & grp_g[k]);
      end
    end
  end

  // Group carry-ins: c[k] = cin&P[0..k-1] | OR_j G[j]&P[j+1..k-1].
  always_comb begin
    logic term;
    term  = 1'b0;
    grp_c = '0;
    grp_c[0] = cin;
    for (int k = 1; k <= NG; k++) begin
      term = cin;
      for (int m = 0; m < k; m++) begin
        term = term & grp_p[m];
      end
      grp_c[k] = term;
      for (int j = 0; j < k; j++) begin
        term = grp_g[j];
        for (int m = j + 1; m < k; m++) begin
          term = term & grp_p[m];
        end
        grp_c[k] = grp_c[k] | term;
      end
    end
  end

  // Bit carries: seeded by the lookahead carry at each group boundary.
  always_comb begin
    c = '0;
    for (int k = 0; k < NG; k++) begin
      c[k*CLA_GROUP] = grp_c[k];
      for (int i = 1; i < CLA_GROUP; i++) begin
        c[k*CLA_GROUP+i] = gen[k*CLA_GROUP+i-1] | (prop[k*CLA_GROUP+i-1] & c[k*CLA_GROUP+i-1]);
      end
    end
    c[WIDTH] = grp_c[NG];
  end

  assign sum          = prop ^ c[WIDTH-1:0];
  assign cout         = c[WIDTH];
  assign msb_carry_in = c[WIDTH-1];

endmodule

// File: rtl/pipelined_alu.sv
// pipelined_alu: two-stage ALU with valid/ready on both sides and NZCV flags.
//   clk, reset (async, active-high), enable (0 freezes every register)
//   in_valid/in_ready, a, b, op, carry_in   - operand beat (captured in S1)
//   out_valid/out_ready, result, zero, negative, carry, overflow - S2 beat
// S1 holds raw operands; the ALU sits between S1 and S2 and S2 holds the
// result and flags. Holds at most two beats, never reorders.
module pipelined_alu
  import alu_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int CLA_GROUP = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  alu_op_t          op,
  input  logic             carry_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             negative,
  output logic             carry,
  output logic             overflow
);

  localparam int SH_W = $clog2(WIDTH);

  // S1 operand registers
  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  alu_op_t          op_q, op_d;
  logic             cin_q, cin_d;

  // S2 result registers
  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             negative_q, negative_d;
  logic             carry_q, carry_d;
  logic             overflow_q, overflow_d;

  logic             s1_load;
  logic             s2_load;

  // Adder datapath
  logic [WIDTH-1:0] add_b;
  logic             add_cin;
  logic [WIDTH-1:0] add_sum;
  logic             add_cout;
  logic             add_cmsb;
  logic             add_ovf;
  logic [SH_W-1:0]  shamt;

  // ALU outputs before S2
  logic [WIDTH-1:0] alu_res;
  logic             alu_carry;
  logic             alu_ovf;

  // S2 takes a beat when S1 has one and S2 is empty or draining this edge;
  // S1 is free whenever it is empty or its beat moves into S2.
  assign s2_load   = enable && s1_valid_q && (!s2_valid_q || out_ready);
  assign s1_load   = enable && (!s1_valid_q || s2_load);
  assign in_ready  = s1_load && !reset;
  assign out_valid = s2_valid_q && enable;

  assign result   = result_q;
  assign zero     = zero_q;
  assign negative = negative_q;
  assign carry    = carry_q;
  assign overflow = overflow_q;

  // Operand select: invert b and pick the carry-in for subtract-style ops.
  always_comb begin
    add_b = is_sub_path(op_q) ? ~b_q : b_q;
    case (op_q)
      OP_ADD:     add_cin = 1'b0;
      OP_ADC:     add_cin = cin_q;
      OP_SUB:     add_cin = 1'b1;
      OP_SBB:     add_cin = ~cin_q;
      OP_CMP_LT:  add_cin = 1'b1;
      OP_CMP_LTU: add_cin = 1'b1;
      default:    add_cin = 1'b0;
    endcase
  end

  cla_adder_n #(
    .WIDTH     (WIDTH),
    .CLA_GROUP (CLA_GROUP)
  ) u_cla (
    .a            (a_q),
    .b            (add_b),
    .cin          (add_cin),
    .sum          (add_sum),
    .cout         (add_cout),
    .msb_carry_in (add_cmsb)
  );

  // Signed overflow of the adder, valid for both a+b and a+~b forms.
  assign add_ovf = add_cout ^ add_cmsb;
  assign shamt   = b_q[SH_W-1:0];

  // Result and carry/overflow selection per opcode.
  always_comb begin
    alu_res   = '0;
    alu_carry = 1'b0;
    alu_ovf   = 1'b0;
    case (op_q)
      OP_ADD, OP_ADC: begin
        alu_res   = add_sum;
        alu_carry = add_cout;
        alu_ovf   = add_ovf;
      end
      OP_SUB, OP_SBB: begin
        alu_res   = add_sum;
        alu_carry = ~add_cout;  // borrow
        alu_ovf   = add_ovf;
      end
      OP_AND:     alu_res = a_q & b_q;
      OP_OR:      alu_res = a_q | b_q;
      OP_XOR:     alu_res = a_q ^ b_q;
      OP_NAND:    alu_res = ~(a_q & b_q);
      OP_NOR:     alu_res = ~(a_q | b_q);
      OP_CMP_EQ:  alu_res = {{(WIDTH-1){1'b0}}, (a_q == b_q)};
      OP_CMP_LT:  alu_res = {{(WIDTH-1){1'b0}}, (add_sum[WIDTH-1] ^ add_ovf)};
      OP_CMP_LTU: alu_res = {{(WIDTH-1){1'b0}}, ~add_cout};
      OP_SLL:     alu_res = a_q << shamt;
      OP_SRL:     alu_res = a_q >> shamt;
      OP_SRA:     alu_res = $signed(a_q) >>> shamt;
      OP_PASS_A:  alu_res = a_q;
      default:    alu_res = '0;
    endcase
  end

  // S1 next state: capture the operand beat whenever S1 is free.
  always_comb begin
    s1_valid_d = s1_valid_q;
    a_d        = a_q;
    b_d        = b_q;
    op_d       = op_q;
    cin_d      = cin_q;
    if (s1_load) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        a_d   = a;
        b_d   = b;
        op_d  = op;
        cin_d = carry_in;
      end else begin
        a_d   = a_q;
      end
    end else begin
      s1_valid_d = s1_valid_q;
    end
  end

  // S2 next state: load result and flags, or retire the beat downstream.
  always_comb begin
    s2_valid_d = s2_valid_q;
    result_d   = result_q;
    zero_d     = zero_q;
    negative_d = negative_q;
    carry_d    = carry_q;
    overflow_d = overflow_q;
    if (s2_load) begin
      s2_valid_d = 1'b1;
      result_d   = alu_res;
      zero_d     = (alu_res == '0);
      negative_d = alu_res[WIDTH-1];
      carry_d    = alu_carry;
      overflow_d = alu_ovf;
    end else if (enable && out_ready) begin
      // Result/flags keep their last value after the beat leaves.
      s2_valid_d = 1'b0;
    end else begin
      s2_valid_d = s2_valid_q;
    end
  end

  // Pipeline registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= OP_ADD;
      cin_q      <= 1'b0;
      s2_valid_q <= 1'b0;
      result_q   <= '0;
      zero_q     <= 1'b0;
      negative_q <= 1'b0;
      carry_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      a_q        <= a_d;
      b_q        <= b_d;
      op_q       <= op_d;
      cin_q      <= cin_d;
      s2_valid_q <= s2_valid_d;
      result_q   <= result_d;
      zero_q     <= zero_d;
      negative_q <= negative_d;
      carry_q    <= carry_d;
      overflow_q <= overflow_d;
    end
  end

endmodule
